// File: rtl/scr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scr_pkg                                                              |
// | Shared constants and types for the scrambling frame controller.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package scr_pkg;

   localparam int c_lfsr_w      = 7;
   localparam int c_lfsr_tap_hi = 6;
   localparam int c_lfsr_tap_lo = 3;
   localparam logic [c_lfsr_w-1:0] c_lfsr_seed = 7'h7F;

   localparam int c_cnt_w = 16;

   typedef logic [1:0] state_t;
   localparam state_t c_st_idle    = 2'd0;
   localparam state_t c_st_sync    = 2'd1;
   localparam state_t c_st_payload = 2'd2;

endpackage
`default_nettype wire

// File: rtl/scr_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scr_lfsr                                                             |
// | Keystream generator, x^7+x^4+1, reloadable to the fixed seed.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module scr_lfsr (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   input  logic step_i,
   output logic key_o
);
   import scr_pkg::*;

   logic [c_lfsr_w-1:0] r_lfsr;

   // Load wins over step so a frame-end transfer reseeds cleanly.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_lfsr <= c_lfsr_seed;
      end else if (load_i) begin
         r_lfsr <= c_lfsr_seed;
      end else if (step_i) begin
         r_lfsr <= {r_lfsr[c_lfsr_w-2:0], r_lfsr[c_lfsr_tap_hi] ^ r_lfsr[c_lfsr_tap_lo]};
      end
   end

   assign key_o = r_lfsr[c_lfsr_tap_hi];

endmodule
`default_nettype wire

// File: rtl/scr_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scr_frame_ctrl                                                       |
// | Serial framer: sync word then LFSR-scrambled payload, 1-cycle delay. |
// | Optional frame counter port enabled by macro SCR_FRAME_STAT_EN.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module scr_frame_ctrl #(
   parameter logic [31:0] SYNC_WORD   = 32'h47,
   parameter int          SYNC_LEN    = 8,
   parameter int          PAYLOAD_LEN = 64
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic        data_i,
   input  logic        valid_i,
   output logic        ready_o,
   output logic        data_o,
   output logic        valid_o,
   output logic        sof_o,
`ifdef SCR_FRAME_STAT_EN
   output logic [15:0] frame_cnt_o,
`endif
   output logic        busy_o
);
   import scr_pkg::*;

   localparam logic [c_cnt_w-1:0] c_sync_last    = c_cnt_w'(SYNC_LEN - 1);
   localparam logic [c_cnt_w-1:0] c_payload_last = c_cnt_w'(PAYLOAD_LEN - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one      = c_cnt_w'(1);
   localparam logic [4:0]         c_sync_msb     = 5'(SYNC_LEN - 1);

   state_t              r_state;
   logic [c_cnt_w-1:0]  r_cnt;
   logic                w_xfer;
   logic                w_frame_end;
   logic                w_load;
   logic                w_key;
   logic                w_sync_bit;

   assign w_xfer      = valid_i && (r_state == c_st_payload);
   assign w_frame_end = w_xfer && (r_cnt == c_payload_last);
   // Reseed on every entry into SYNC, whether from IDLE or back-to-back.
   assign w_load      = en_i && ((r_state == c_st_idle) || w_frame_end);
   assign w_sync_bit  = SYNC_WORD[c_sync_msb - r_cnt[4:0]];

   assign ready_o = (r_state == c_st_payload);
   assign busy_o  = (r_state != c_st_idle);

   scr_lfsr u_lfsr (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (w_load),
      .step_i (w_xfer),
      .key_o  (w_key)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= c_st_idle;
         r_cnt   <= '0;
         data_o  <= 1'b0;
         valid_o <= 1'b0;
         sof_o   <= 1'b0;
      end else begin
         data_o  <= 1'b0;
         valid_o <= 1'b0;
         sof_o   <= 1'b0;
         case (r_state)
            c_st_idle: begin
               if (en_i) begin
                  r_state <= c_st_sync;
                  r_cnt   <= '0;
               end
            end
            c_st_sync: begin
               data_o  <= w_sync_bit;
               valid_o <= 1'b1;
               sof_o   <= (r_cnt == '0);
               if (r_cnt == c_sync_last) begin
                  r_state <= c_st_payload;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + c_cnt_one;
               end
            end
            c_st_payload: begin
               if (w_xfer) begin
                  data_o  <= data_i ^ w_key;
                  valid_o <= 1'b1;
                  if (w_frame_end) begin
                     r_cnt   <= '0;
                     r_state <= en_i ? c_st_sync : c_st_idle;
                  end else begin
                     r_cnt <= r_cnt + c_cnt_one;
                  end
               end
            end
            default: begin
               r_state <= c_st_idle;
               r_cnt   <= '0;
            end
         endcase
      end
   end

`ifdef SCR_FRAME_STAT_EN
   logic [15:0] r_frame_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_frame_cnt <= '0;
      end else if (w_frame_end) begin
         r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   assign frame_cnt_o = r_frame_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_scr_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_scr_frame_ctrl                                                    |
// | Directed + random bench for scr_frame_ctrl against a stream model.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_scr_frame_ctrl;

   localparam int SYNC_LEN    = 8;
   localparam int PAYLOAD_LEN = 64;
   localparam int FRAME_BITS  = SYNC_LEN + PAYLOAD_LEN;

   logic clk_i = 1'b0;
   logic rst_i, en_i, data_i, valid_i;
   logic ready_o, data_o, valid_o, sof_o, busy_o;
`ifdef SCR_FRAME_STAT_EN
   logic [15:0] frame_cnt_o;
`endif

   scr_frame_ctrl #(
      .SYNC_WORD   (32'h47),
      .SYNC_LEN    (SYNC_LEN),
      .PAYLOAD_LEN (PAYLOAD_LEN)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .en_i        (en_i),
      .data_i      (data_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .sof_o       (sof_o),
`ifdef SCR_FRAME_STAT_EN
      .frame_cnt_o (frame_cnt_o),
`endif
      .busy_o      (busy_o)
   );

   always #5 clk_i = ~clk_i;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   // Stream model: position within the frame, keystream by recurrence.
   logic [31:0] sync_pat = 32'h47;
   bit          ks[PAYLOAD_LEN];
   bit          m_active;
   int          m_pos;
   int          m_frames;
   bit          e_valid, e_sof, e_data;

   bit q_bits[$];
   int q_time[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   function automatic logic [7:0] pack8(input int start);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[7-i] = q_bits[start+i];
      return b;
   endfunction

   task automatic model_step();
      e_valid = 0; e_sof = 0; e_data = 0;
      if (rst_i) begin
         m_active = 0; m_pos = 0; m_frames = 0;
      end else if (!m_active) begin
         if (en_i) begin m_active = 1; m_pos = 0; end
      end else if (m_pos < SYNC_LEN) begin
         e_valid = 1;
         e_data  = sync_pat[SYNC_LEN-1-m_pos];
         e_sof   = (m_pos == 0);
         m_pos++;
      end else if (valid_i) begin
         e_valid = 1;
         e_data  = data_i ^ ks[m_pos-SYNC_LEN];
         m_pos++;
         if (m_pos == FRAME_BITS) begin
            m_frames++;
            m_pos    = 0;
            m_active = en_i;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      model_step();
      cyc++;
      @(negedge clk_i);
      check("valid_o", valid_o, e_valid);
      check("sof_o", sof_o, e_sof);
      if (e_valid) check("data_o", data_o, e_data);
      check("busy_o", busy_o, m_active);
      check("ready_o", ready_o, m_active && (m_pos >= SYNC_LEN));
`ifdef SCR_FRAME_STAT_EN
      check("frame_cnt_o", frame_cnt_o, 16'(m_frames));
`endif
      if (valid_o) begin q_bits.push_back(data_o); q_time.push_back(cyc); end
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      #1;
      check("rst_ready", ready_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_valid", valid_o, 0);
      check("rst_sof", sof_o, 0);
      check("rst_data", data_o, 0);
      model_step();
`ifdef SCR_FRAME_STAT_EN
      check("rst_frame_cnt", frame_cnt_o, 0);
`endif
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit done;
      logic [7:0] exp_pl [3];
      exp_pl[0] = 8'hFE; exp_pl[1] = 8'h01; exp_pl[2] = 8'hFE;

      for (int n = 0; n < PAYLOAD_LEN; n++)
         ks[n] = (n < 7) ? 1'b1 : (ks[n-7] ^ ks[n-4]);

      rst_i = 0; en_i = 0; valid_i = 0; data_i = 0;
      m_active = 0; m_pos = 0; m_frames = 0;
      @(negedge clk_i);
      do_reset();

      // Three back-to-back frames: zeros, ones, then alternating valid with en dropped.
      q_bits.delete(); q_time.delete();
      en_i = 1; valid_i = 1; data_i = 0;
      done = 0;
      for (int i = 0; i < 1000; i++) begin
         if (m_frames == 3) begin done = 1; break; end
         if (m_frames == 0) begin valid_i = 1; data_i = 0; end
         else if (m_frames == 1) begin valid_i = 1; data_i = 1; end
         else begin
            valid_i = ~valid_i; data_i = 0;
            if (m_active && m_pos >= SYNC_LEN + 10) en_i = 0;
         end
         tick();
      end
      check("A_bound", done, 1);
      en_i = 0; valid_i = 1;
      tick();
      tick();
      check("A_nbits", q_bits.size(), 3 * FRAME_BITS);
      if (q_bits.size() >= 3 * FRAME_BITS) begin
         for (int f = 0; f < 3; f++) begin
            check($sformatf("A_sync%0d", f), pack8(f * FRAME_BITS), 8'h47);
            check($sformatf("A_pl%0d", f), pack8(f * FRAME_BITS + SYNC_LEN), exp_pl[f]);
         end
         check("A_gapless", q_time[2*FRAME_BITS-1] - q_time[0], 2 * FRAME_BITS - 1);
      end
`ifdef SCR_FRAME_STAT_EN
      check("A_frame_cnt", frame_cnt_o, 3);
`endif

      // Random traffic, then reset at payload bit 20.
      en_i = 1;
      done = 0;
      for (int i = 0; i < 300; i++) begin
         if (m_active && m_pos == SYNC_LEN + 20) begin done = 1; break; end
         valid_i = ($urandom_range(0, 3) != 0);
         data_i  = 1'($urandom);
         tick();
      end
      check("B_bound", done, 1);
      do_reset();
      q_bits.delete(); q_time.delete();
      en_i = 1; valid_i = 1; data_i = 0;
      for (int i = 0; i < 1 + SYNC_LEN + 8; i++) tick();
      check("B_nbits", q_bits.size(), SYNC_LEN + 8);
      if (q_bits.size() >= 16) begin
         check("B_sync", pack8(0), 8'h47);
         check("B_pl", pack8(8), 8'hFE);
      end

      // Long random run checked cycle by cycle.
      for (int i = 0; i < 3000; i++) begin
         en_i    = ($urandom_range(0, 4) != 0);
         valid_i = ($urandom_range(0, 3) != 0);
         data_i  = 1'($urandom);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
